// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch front end and the decoder:
// micro-step codes, trap causes, the NOP encoding and the sequencer FSM states.
package fetch_sequencer_pkg;

  localparam logic [2:0] STEP_0    = 3'd0;
  localparam logic [2:0] STEP_1    = 3'd1;
  localparam logic [2:0] STEP_2    = 3'd2;
  localparam logic [2:0] STEP_DONE = 3'd3;

  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ACCESS     = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } fsm_state_e;

  // Instruction fetches must be 32-bit aligned.
  function automatic logic word_aligned(input logic [1:0] lo);
    return (lo == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: Wishbone-classic fetch, IR / micro-step register,
// PC ownership and trap generation for misaligned, faulting or illegal instructions.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h0),
  parameter logic [ADDR_W-1:0] TRAP_PC  = ADDR_W'(64'h100)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] iadr_o,
  output logic              icyc_o,
  output logic              istb_o,
  input  logic              iack_i,
  input  logic              ierr_i,
  input  logic [31:0]       idat_i,
  output logic [31:0]       ir_o,
  output logic [2:0]        state_o,
  input  logic [2:0]        nstate_i,
  input  logic              defined_i,
  input  logic              pc_ld_i,
  input  logic [ADDR_W-1:0] pc_new_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] ipc_o,
  output logic              trap_o,
  output logic [3:0]        cause_o,
  output logic [ADDR_W-1:0] epc_o
);

  fsm_state_e        state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [ADDR_W-1:0] ipc_r, ipc_nxt_s;
  logic [ADDR_W-1:0] epc_r, epc_nxt_s;
  logic [ADDR_W-1:0] exec_pc_s;
  logic [31:0]       ir_r, ir_nxt_s;
  logic [2:0]        step_r, step_nxt_s;
  logic [3:0]        cause_r, cause_nxt_s;
  logic              icyc_r, icyc_nxt_s;
  logic              trap_r, trap_nxt_s;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a bus error outranks a simultaneous ack.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (icyc_r) begin
          if (ierr_i) begin
            state_nxt_s = S_TRAP;
          end else if (iack_i) begin
            state_nxt_s = S_EXEC;
          end else begin
            state_nxt_s = S_FETCH;
          end
        end else if (!word_aligned(pc_r[1:0])) begin
          state_nxt_s = S_TRAP;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_EXEC: begin
        if (!defined_i) begin
          state_nxt_s = S_TRAP;
        end else if (nstate_i == STEP_DONE) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_TRAP:  state_nxt_s = S_FETCH;
      default: state_nxt_s = S_FETCH;
    endcase
  end

  // FSM output logic: next values of every registered output.
  always_comb begin
    pc_nxt_s    = pc_r;
    ipc_nxt_s   = ipc_r;
    epc_nxt_s   = epc_r;
    ir_nxt_s    = ir_r;
    step_nxt_s  = step_r;
    cause_nxt_s = cause_r;
    icyc_nxt_s  = icyc_r;
    trap_nxt_s  = 1'b0;
    exec_pc_s   = pc_ld_i ? pc_new_i : pc_r;
    case (state_r)
      S_FETCH: begin
        if (icyc_r) begin
          if (ierr_i) begin
            icyc_nxt_s  = 1'b0;
            trap_nxt_s  = 1'b1;
            cause_nxt_s = CAUSE_ACCESS;
            epc_nxt_s   = pc_r;
          end else if (iack_i) begin
            icyc_nxt_s = 1'b0;
            ir_nxt_s   = idat_i;
            ipc_nxt_s  = pc_r;
            pc_nxt_s   = pc_r + {{(ADDR_W-3){1'b0}}, 3'd4};
            step_nxt_s = STEP_0;
          end else begin
            icyc_nxt_s = 1'b1;
          end
        end else if (!word_aligned(pc_r[1:0])) begin
          trap_nxt_s  = 1'b1;
          cause_nxt_s = CAUSE_MISALIGNED;
          epc_nxt_s   = pc_r;
        end else begin
          icyc_nxt_s = 1'b1;
        end
      end
      S_EXEC: begin
        if (!defined_i) begin
          trap_nxt_s  = 1'b1;
          cause_nxt_s = CAUSE_ILLEGAL;
          epc_nxt_s   = ipc_r;
        end else begin
          step_nxt_s = nstate_i;
          pc_nxt_s   = exec_pc_s;
          // The bus cycle opens together with the transition so fetch starts at once.
          icyc_nxt_s = (nstate_i == STEP_DONE) && word_aligned(exec_pc_s[1:0]);
        end
      end
      S_TRAP: begin
        pc_nxt_s   = TRAP_PC;
        step_nxt_s = STEP_DONE;
        icyc_nxt_s = word_aligned(TRAP_PC[1:0]);
      end
      default: begin
        icyc_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pc_r    <= RESET_PC;
      ipc_r   <= RESET_PC;
      epc_r   <= {ADDR_W{1'b0}};
      ir_r    <= NOP_INSN;
      step_r  <= STEP_DONE;
      cause_r <= CAUSE_MISALIGNED;
      icyc_r  <= 1'b0;
      trap_r  <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      ipc_r   <= ipc_nxt_s;
      epc_r   <= epc_nxt_s;
      ir_r    <= ir_nxt_s;
      step_r  <= step_nxt_s;
      cause_r <= cause_nxt_s;
      icyc_r  <= icyc_nxt_s;
      trap_r  <= trap_nxt_s;
    end
  end

  assign iadr_o  = {pc_r[ADDR_W-1:2], 2'b00};
  assign icyc_o  = icyc_r;
  assign istb_o  = icyc_r;
  assign ir_o    = ir_r;
  assign state_o = step_r;
  assign pc_o    = pc_r;
  assign ipc_o   = ipc_r;
  assign trap_o  = trap_r;
  assign cause_o = cause_r;
  assign epc_o   = epc_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a scoreboard of expected fetch addresses
// and trap records, popped when the DUT opens a bus cycle or pulses trap_o.
module tb_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] iadr_o;
  logic        icyc_o, istb_o;
  logic        iack_i, ierr_i;
  logic [31:0] idat_i, ir_o;
  logic [2:0]  state_o, nstate_i;
  logic        defined_i, pc_ld_i;
  logic [63:0] pc_new_i, pc_o, ipc_o, epc_o;
  logic        trap_o;
  logic [3:0]  cause_o;

  typedef struct packed {
    logic [3:0]  cause;
    logic [63:0] epc;
  } trap_rec_t;

  logic [63:0] adr_q[$];
  trap_rec_t   trap_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        prev_icyc_r = 1'b0;
  logic        prev_trap_r = 1'b0;

  always #5 clk_i = ~clk_i;

  fetch_sequencer dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .iadr_o    (iadr_o),
    .icyc_o    (icyc_o),
    .istb_o    (istb_o),
    .iack_i    (iack_i),
    .ierr_i    (ierr_i),
    .idat_i    (idat_i),
    .ir_o      (ir_o),
    .state_o   (state_o),
    .nstate_i  (nstate_i),
    .defined_i (defined_i),
    .pc_ld_i   (pc_ld_i),
    .pc_new_i  (pc_new_i),
    .pc_o      (pc_o),
    .ipc_o     (ipc_o),
    .trap_o    (trap_o),
    .cause_o   (cause_o),
    .epc_o     (epc_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: bus-cycle starts and trap pulses consume expected records.
  always @(negedge clk_i) begin
    if (icyc_o && !prev_icyc_r) begin
      if (adr_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL fetch_unexpected: bus cycle at %h with no expected fetch", iadr_o);
      end else begin
        chk("fetch_adr", iadr_o, adr_q.pop_front());
      end
    end
    if (icyc_o) chk("stb_eq_cyc", {63'd0, istb_o}, {63'd0, icyc_o});
    if (trap_o) begin
      chk("trap_one_pulse", {63'd0, prev_trap_r}, 64'd0);
      if (trap_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL trap_unexpected: trap cause %h epc %h", cause_o, epc_o);
      end else begin
        trap_rec_t t;
        t = trap_q.pop_front();
        chk("trap_cause", {60'd0, cause_o}, {60'd0, t.cause});
        chk("trap_epc", epc_o, t.epc);
      end
    end
    prev_icyc_r <= icyc_o;
    prev_trap_r <= trap_o;
  end

  task automatic wait_bus();
    int k = 0;
    while (!icyc_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    chk("bus_start", {63'd0, icyc_o}, 64'd1);
  endtask

  task automatic fetch_ok(input int waits, input logic [31:0] data, input logic [63:0] adr);
    logic [63:0] nxt;
    wait_bus();
    chk("fetch_iadr", iadr_o, adr);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk_i);
      chk("wait_cyc", {63'd0, icyc_o}, 64'd1);
      chk("wait_adr", iadr_o, adr);
    end
    idat_i = data;
    iack_i = 1'b1;
    @(negedge clk_i);
    iack_i = 1'b0;
    nxt = adr + 64'd4;
    chk("ir", {32'd0, ir_o}, {32'd0, data});
    chk("ipc", ipc_o, adr);
    chk("pc_inc", pc_o, nxt);
    chk("state_start", {61'd0, state_o}, 64'd0);
    chk("cyc_drop", {63'd0, icyc_o}, 64'd0);
  endtask

  task automatic step(input logic [2:0] ns, input logic ld, input logic [63:0] tgt);
    nstate_i = ns;
    pc_ld_i  = ld;
    pc_new_i = tgt;
    @(negedge clk_i);
    pc_ld_i = 1'b0;
    chk("state_step", {61'd0, state_o}, {61'd0, ns});
  endtask

  initial begin
    reset_i = 1'b0; iack_i = 1'b0; ierr_i = 1'b0; idat_i = 32'd0;
    nstate_i = 3'd0; defined_i = 1'b1; pc_ld_i = 1'b0; pc_new_i = 64'd0;
    repeat (2) @(negedge clk_i);
    chk("rst_cyc", {63'd0, icyc_o}, 64'd0);
    chk("rst_stb", {63'd0, istb_o}, 64'd0);
    chk("rst_trap", {63'd0, trap_o}, 64'd0);
    chk("rst_iadr", iadr_o, 64'd0);
    chk("rst_pc", pc_o, 64'd0);
    chk("rst_ipc", ipc_o, 64'd0);
    chk("rst_ir", {32'd0, ir_o}, 64'h13);
    chk("rst_state", {61'd0, state_o}, 64'd3);
    chk("rst_cause", {60'd0, cause_o}, 64'd0);
    chk("rst_epc", epc_o, 64'd0);
    adr_q.push_back(64'd0);
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_cyc", {63'd0, icyc_o}, 64'd1);
    chk("post_rst_adr", iadr_o, 64'd0);

    // Normal fetch with wait states and micro-steps.
    fetch_ok(2, 32'h0420_0093, 64'd0);
    step(3'd1, 1'b0, 64'd0);
    step(3'd2, 1'b0, 64'd0);
    adr_q.push_back(64'd4);
    step(3'd3, 1'b0, 64'd0);
    chk("refetch_cyc", {63'd0, icyc_o}, 64'd1);
    chk("refetch_adr", iadr_o, 64'd4);
    fetch_ok(0, 32'h0000_0013, 64'd4);
    adr_q.push_back(64'd8);
    step(3'd3, 1'b0, 64'd0);

    // Illegal instruction outranks a simultaneous redirect and done step.
    fetch_ok(1, 32'hFFFF_FFFF, 64'd8);
    step(3'd1, 1'b0, 64'd0);
    step(3'd2, 1'b0, 64'd0);
    trap_q.push_back({4'd2, 64'd8});
    adr_q.push_back(64'h100);
    defined_i = 1'b0; nstate_i = 3'd3; pc_ld_i = 1'b1; pc_new_i = 64'h200;
    @(negedge clk_i);
    defined_i = 1'b1; pc_ld_i = 1'b0;
    chk("ill_trap", {63'd0, trap_o}, 64'd1);
    @(negedge clk_i);
    chk("ill_trap_drop", {63'd0, trap_o}, 64'd0);
    chk("ill_state", {61'd0, state_o}, 64'd3);
    chk("ill_pc", pc_o, 64'h100);
    chk("ill_epc_hold", epc_o, 64'd8);

    // Bus error wins over a simultaneous ack.
    fetch_ok(0, 32'h0010_0113, 64'h100);
    adr_q.push_back(64'h10);
    step(3'd3, 1'b1, 64'h10);
    wait_bus();
    trap_q.push_back({4'd1, 64'h10});
    adr_q.push_back(64'h100);
    idat_i = 32'hBAD0_BAD0; iack_i = 1'b1; ierr_i = 1'b1;
    @(negedge clk_i);
    iack_i = 1'b0; ierr_i = 1'b0;
    chk("err_trap", {63'd0, trap_o}, 64'd1);
    chk("err_ir_hold", {32'd0, ir_o}, 64'h0010_0113);
    @(negedge clk_i);
    chk("err_trap_drop", {63'd0, trap_o}, 64'd0);

    // Redirects: last one wins, then a misaligned target.
    fetch_ok(0, 32'h0000_006F, 64'h100);
    step(3'd1, 1'b1, 64'h80);
    adr_q.push_back(64'h40);
    step(3'd3, 1'b1, 64'h40);
    fetch_ok(0, 32'h0000_0013, 64'h40);
    trap_q.push_back({4'd0, 64'h42});
    adr_q.push_back(64'h100);
    step(3'd3, 1'b1, 64'h42);
    chk("mis_no_cyc", {63'd0, icyc_o}, 64'd0);
    chk("mis_pc", pc_o, 64'h42);
    @(negedge clk_i);
    chk("mis_trap", {63'd0, trap_o}, 64'd1);
    chk("mis_trap_no_cyc", {63'd0, icyc_o}, 64'd0);

    // PC wraps at the top of the address space.
    fetch_ok(0, 32'h0000_0013, 64'h100);
    adr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    step(3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_ok(0, 32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc", pc_o, 64'd0);
    adr_q.push_back(64'd0);
    step(3'd3, 1'b0, 64'd0);

    // Reset during an unacked cycle; the late ack must be ignored.
    wait_bus();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_cyc", {63'd0, icyc_o}, 64'd0);
    chk("mid_rst_state", {61'd0, state_o}, 64'd3);
    chk("mid_rst_pc", pc_o, 64'd0);
    chk("mid_rst_ir", {32'd0, ir_o}, 64'h13);
    adr_q.push_back(64'd0);
    reset_i = 1'b1; idat_i = 32'h1234_5678; iack_i = 1'b1;
    @(negedge clk_i);
    iack_i = 1'b0;
    chk("late_ack_ir", {32'd0, ir_o}, 64'h13);
    chk("late_ack_state", {61'd0, state_o}, 64'd3);
    chk("late_ack_cyc", {63'd0, icyc_o}, 64'd1);
    fetch_ok(1, 32'h0050_0093, 64'd0);

    chk("adr_q_empty", 64'(adr_q.size()), 64'd0);
    chk("trap_q_empty", 64'(trap_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
